// File: rtl/mine_field_gen_pkg.sv
// Shared definitions for the minefield generator: FSM state encoding,
// default grid / mine constants and a small state helper.
package mine_field_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_PLACE = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   localparam int DEF_X_W       = 4;
   localparam int DEF_Y_W       = 4;
   localparam int DEF_COLS      = 16;
   localparam int DEF_ROWS      = 16;
   localparam int DEF_MAX_MINES = 40;
   localparam int DEF_SAFE_R    = 1;
   localparam int DEF_RAND_W    = 16;
   localparam int DEF_MAX_TRIES = 4096;

   // States in which a start request is accepted.
   function automatic logic accepts_start(state_t s);
      return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
   endfunction

endpackage

// File: rtl/mine_field_gen_if.sv
// Control / status / board-RAM write bundle of the minefield generator.
// master = game controller side, slave = generator side.
interface mine_field_gen_if
   import mine_field_gen_pkg::*;
#(
   parameter int ADDR_W = DEF_X_W + DEF_Y_W,
   parameter int CNT_W  = $clog2(DEF_MAX_MINES + 1),
   parameter int RAND_W = DEF_RAND_W
) ();

   logic [RAND_W-1:0] random_number;
   logic              start;
   logic [CNT_W-1:0]  num_mines;
   logic [ADDR_W-1:0] safe_center_addr;
   logic              busy;
   logic              alg_done;
   logic              alg_err;
   logic [CNT_W-1:0]  mine_total;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_in;
   logic              mem_wren;

   modport master (
      output random_number, start, num_mines, safe_center_addr,
      input  busy, alg_done, alg_err, mine_total, mem_addr, mem_in, mem_wren
   );

   modport slave (
      input  random_number, start, num_mines, safe_center_addr,
      output busy, alg_done, alg_err, mine_total, mem_addr, mem_in, mem_wren
   );

endinterface

// File: rtl/mine_field_gen_cand_filter.sv
// Combinational candidate generator: folds the random word into one cell
// address and flags whether that cell lies inside the active grid and
// outside the safe zone around the first click. The used map is not
// considered here.
module mine_cand_filter
   import mine_field_gen_pkg::*;
#(
   parameter int X_W    = DEF_X_W,
   parameter int Y_W    = DEF_Y_W,
   parameter int COLS   = DEF_COLS,
   parameter int ROWS   = DEF_ROWS,
   parameter int SAFE_R = DEF_SAFE_R,
   parameter int RAND_W = DEF_RAND_W
) (
   input  logic [RAND_W-1:0]    random_number,
   input  logic [X_W+Y_W-1:0]   safe_center_addr,
   output logic [X_W+Y_W-1:0]   cand,
   output logic                 cand_ok
);

   localparam int ADDR_W = X_W + Y_W;
   localparam int NSLICE = (RAND_W + ADDR_W - 1) / ADDR_W;

   logic [NSLICE*ADDR_W-1:0] w_pad;
   logic [ADDR_W-1:0]        w_fold;
   logic [X_W-1:0]           w_x, w_sx;
   logic [Y_W-1:0]           w_y, w_sy;
   logic signed [X_W:0]      w_dx;
   logic signed [Y_W:0]      w_dy;
   logic                     w_in_grid;
   logic                     w_in_zone;

   // Top slice is zero-padded so every slice is a full address wide.
   assign w_pad = (NSLICE*ADDR_W)'(random_number);

   // XOR all address-wide slices together.
   always_comb begin
      w_fold = '0;
      for (int i = 0; i < NSLICE; i++) begin
         w_fold = w_fold ^ w_pad[i*ADDR_W +: ADDR_W];
      end
   end

   assign cand = w_fold;
   assign w_x  = w_fold[X_W-1:0];
   assign w_y  = w_fold[ADDR_W-1:X_W];
   assign w_sx = safe_center_addr[X_W-1:0];
   assign w_sy = safe_center_addr[ADDR_W-1:X_W];

   // Deltas carry one extra bit so a cell left of / above the centre is
   // negative rather than wrapping to a large unsigned value.
   assign w_dx = $signed({1'b0, w_x}) - $signed({1'b0, w_sx});
   assign w_dy = $signed({1'b0, w_y}) - $signed({1'b0, w_sy});

   assign w_in_grid = (int'(w_x) < COLS) && (int'(w_y) < ROWS);
   assign w_in_zone = (int'(w_dx) <= SAFE_R) && (int'(w_dx) >= -SAFE_R) &&
                      (int'(w_dy) <= SAFE_R) && (int'(w_dy) >= -SAFE_R);

   assign cand_ok = w_in_grid && !w_in_zone;

endmodule

// File: rtl/mine_field_gen.sv
// Minefield generator: clears the whole board RAM, then places num_mines
// distinct mines at random in-grid cells outside the first-click safe zone.
// Optional feature: define MINE_FIELD_GEN_WATCHDOG_EN to abort to ERR after
// MAX_TRIES consecutive rejected candidates.
module mine_field_gen
   import mine_field_gen_pkg::*;
#(
   parameter int X_W       = DEF_X_W,
   parameter int Y_W       = DEF_Y_W,
   parameter int COLS      = DEF_COLS,
   parameter int ROWS      = DEF_ROWS,
   parameter int MAX_MINES = DEF_MAX_MINES,
   parameter int SAFE_R    = DEF_SAFE_R,
   parameter int RAND_W    = DEF_RAND_W,
   parameter int MAX_TRIES = DEF_MAX_TRIES
) (
   input  logic             clk,
   input  logic             rst,
   mine_field_gen_if.slave  bus
);

   localparam int ADDR_W = X_W + Y_W;
   localparam int CNT_W  = $clog2(MAX_MINES + 1);
   localparam int NCELL  = 2 ** ADDR_W;

   if (COLS < 1 || COLS > 2**X_W || ROWS < 1 || ROWS > 2**Y_W ||
       SAFE_R < 0 || MAX_TRIES < 1) begin : g_bad_param
      $error("mine_field_gen: illegal parameter combination");
   end

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_clr_addr, w_clr_addr_nxt;
   logic [NCELL-1:0]  r_used, w_used_nxt;
   logic [CNT_W-1:0]  r_num, w_num_nxt;
   logic [CNT_W-1:0]  r_total, w_total_nxt, w_total_inc;
   logic [ADDR_W-1:0] r_center, w_center_nxt;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
   logic              r_mem_in, w_mem_in_nxt;
   logic              r_wren, w_wren_nxt;
   logic              r_busy, r_done, r_err;
   logic [ADDR_W-1:0] w_cand;
   logic              w_cand_ok;
`ifdef MINE_FIELD_GEN_WATCHDOG_EN
   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   logic [TRY_W-1:0]  r_tries, w_tries_nxt;
`endif

   mine_cand_filter #(
      .X_W    (X_W),
      .Y_W    (Y_W),
      .COLS   (COLS),
      .ROWS   (ROWS),
      .SAFE_R (SAFE_R),
      .RAND_W (RAND_W)
   ) u_filter (
      .random_number    (bus.random_number),
      .safe_center_addr (r_center),
      .cand             (w_cand),
      .cand_ok          (w_cand_ok)
   );

   assign w_total_inc = r_total + 1'b1;

   // Next-state and next-register values for the FSM and write port.
   always_comb begin
      w_state_nxt    = r_state;
      w_clr_addr_nxt = r_clr_addr;
      w_used_nxt     = r_used;
      w_num_nxt      = r_num;
      w_total_nxt    = r_total;
      w_center_nxt   = r_center;
      w_mem_addr_nxt = r_mem_addr;
      w_mem_in_nxt   = 1'b0;
      w_wren_nxt     = 1'b0;
`ifdef MINE_FIELD_GEN_WATCHDOG_EN
      w_tries_nxt    = r_tries;
`endif
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (bus.start && accepts_start(r_state)) begin
               w_num_nxt      = bus.num_mines;
               w_center_nxt   = bus.safe_center_addr;
               w_total_nxt    = '0;
               w_used_nxt     = '0;
               w_clr_addr_nxt = '0;
`ifdef MINE_FIELD_GEN_WATCHDOG_EN
               w_tries_nxt    = '0;
`endif
               if (int'(bus.num_mines) > MAX_MINES) w_state_nxt = ST_ERR;
               else                                 w_state_nxt = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            w_wren_nxt     = 1'b1;
            w_mem_addr_nxt = r_clr_addr;
            w_mem_in_nxt   = 1'b0;
            w_clr_addr_nxt = r_clr_addr + 1'b1;
            if (&r_clr_addr) begin
               w_state_nxt = (r_num == '0) ? ST_DONE : ST_PLACE;
            end
         end
         ST_PLACE: begin
            if (w_cand_ok && !r_used[w_cand]) begin
               w_wren_nxt         = 1'b1;
               w_mem_addr_nxt     = w_cand;
               w_mem_in_nxt       = 1'b1;
               w_used_nxt[w_cand] = 1'b1;
               w_total_nxt        = w_total_inc;
`ifdef MINE_FIELD_GEN_WATCHDOG_EN
               w_tries_nxt        = '0;
`endif
               if (w_total_inc == r_num) w_state_nxt = ST_DONE;
            end else begin
`ifdef MINE_FIELD_GEN_WATCHDOG_EN
               if (r_tries == TRY_W'(MAX_TRIES - 1)) w_state_nxt = ST_ERR;
               else                                  w_tries_nxt = r_tries + 1'b1;
`endif
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State, bookkeeping and registered outputs; reset aborts any run.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_clr_addr <= '0;
         r_used     <= '0;
         r_num      <= '0;
         r_total    <= '0;
         r_center   <= '0;
         r_mem_addr <= '0;
         r_mem_in   <= 1'b0;
         r_wren     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
`ifdef MINE_FIELD_GEN_WATCHDOG_EN
         r_tries    <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= w_clr_addr_nxt;
         r_used     <= w_used_nxt;
         r_num      <= w_num_nxt;
         r_total    <= w_total_nxt;
         r_center   <= w_center_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_mem_in   <= w_mem_in_nxt;
         r_wren     <= w_wren_nxt;
         r_busy     <= (w_state_nxt == ST_CLEAR) || (w_state_nxt == ST_PLACE);
         r_done     <= (w_state_nxt == ST_DONE);
         r_err      <= (w_state_nxt == ST_ERR);
`ifdef MINE_FIELD_GEN_WATCHDOG_EN
         r_tries    <= w_tries_nxt;
`endif
      end
   end

   assign bus.busy       = r_busy;
   assign bus.alg_done   = r_done;
   assign bus.alg_err    = r_err;
   assign bus.mine_total = r_total;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_in     = r_mem_in;
   assign bus.mem_wren   = r_wren;

endmodule

// File: tb/tb_mine_field_gen.sv
// Directed bench for mine_field_gen: full 16x16 board, a 9x9 board,
// error requests, mid-run start/reset, and a stuck random source.
module tb_mine_field_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stuck = 1'b0;
   logic [15:0] lfsr = 16'hACE1;

   int n_checks = 0;
   int n_err    = 0;

   mine_field_gen_if #(.ADDR_W(8), .CNT_W(6), .RAND_W(16)) bus  ();
   mine_field_gen_if #(.ADDR_W(8), .CNT_W(6), .RAND_W(16)) bus9 ();

   mine_field_gen #(
      .X_W(4), .Y_W(4), .COLS(16), .ROWS(16), .MAX_MINES(40),
      .SAFE_R(1), .RAND_W(16), .MAX_TRIES(16)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   mine_field_gen #(
      .X_W(4), .Y_W(4), .COLS(9), .ROWS(9), .MAX_MINES(40),
      .SAFE_R(1), .RAND_W(16), .MAX_TRIES(16)
   ) u_dut9 (
      .clk (clk),
      .rst (rst),
      .bus (bus9.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

   assign bus.random_number  = stuck ? 16'h0000 : lfsr;
   assign bus9.random_number = lfsr;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input bit sel, input int num, input logic [7:0] centre);
      @(negedge clk);
      if (sel) begin
         bus9.start = 1'b1; bus9.num_mines = 6'(num); bus9.safe_center_addr = centre;
      end else begin
         bus.start = 1'b1;  bus.num_mines = 6'(num);  bus.safe_center_addr = centre;
      end
      @(negedge clk);
      bus.start  = 1'b0;
      bus9.start = 1'b0;
   endtask

   // Watch writes until done/err (or budget), gathering statistics.
   int n_clr, n_mine, n_dup, n_bad, n_early, n_cyc, first_mine;
   task automatic watch(input bit sel, input int sx, input int sy, input int cols,
                        input int rows, input int budget);
      logic [255:0] seen;
      logic wr, mi, dn, er;
      logic [7:0] ad;
      int x, y, dx, dy;
      seen = '0;
      n_clr = 0; n_mine = 0; n_dup = 0; n_bad = 0; n_early = 0; n_cyc = -1; first_mine = -1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (sel) begin
            wr = bus9.mem_wren; mi = bus9.mem_in; ad = bus9.mem_addr;
            dn = bus9.alg_done; er = bus9.alg_err;
         end else begin
            wr = bus.mem_wren;  mi = bus.mem_in;  ad = bus.mem_addr;
            dn = bus.alg_done;  er = bus.alg_err;
         end
         if (wr) begin
            if (!mi) begin
               if (ad != 8'(n_clr)) n_bad++;
               n_clr++;
            end else begin
               x = int'(ad[3:0]); y = int'(ad[7:4]);
               dx = x - sx; dy = y - sy;
               if (dx < 0) dx = -dx;
               if (dy < 0) dy = -dy;
               if (seen[ad]) n_dup++;
               seen[ad] = 1'b1;
               if (x >= cols || y >= rows || (dx <= 1 && dy <= 1)) n_bad++;
               if (n_clr < 256) n_early++;
               if (first_mine < 0) first_mine = int'(ad);
               n_mine++;
            end
         end
         if (dn || er) begin
            n_cyc = c;
            break;
         end
      end
   endtask

   task automatic wait_total(input int k, input int budget);
      int c;
      c = 0;
      while (int'(bus.mine_total) < k && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("wait_total_reached", longint'(int'(bus.mine_total) >= k), 1);
   endtask

   initial begin
      bus.start = 1'b0;  bus.num_mines = '0;  bus.safe_center_addr = '0;
      bus9.start = 1'b0; bus9.num_mines = '0; bus9.safe_center_addr = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {bus.busy, bus.alg_done, bus.alg_err, bus.mine_total,
                              bus.mem_addr, bus.mem_in, bus.mem_wren}, 0);
      rst = 1'b1;
      @(negedge clk);

      // 1: full board, 40 mines, centre (7,7)
      pulse_start(0, 40, 8'h77);
      check("t1_busy_after_start", bus.busy, 1);
      watch(0, 7, 7, 16, 16, 3000);
      check("t1_clear_writes", n_clr, 256);
      check("t1_mine_writes", n_mine, 40);
      check("t1_dup", n_dup, 0);
      check("t1_bad_cell", n_bad, 0);
      check("t1_mine_before_clear", n_early, 0);
      check("t1_finished", longint'(n_cyc >= 0), 1);
      check("t1_total", bus.mine_total, 40);
      check("t1_done", bus.alg_done, 1);
      check("t1_busy", bus.busy, 0);
      @(negedge clk);
      check("t1_done_holds", bus.alg_done, 1);
      check("t1_no_write_in_done", bus.mem_wren, 0);

      // 2: zero mines
      pulse_start(0, 0, 8'h77);
      watch(0, 7, 7, 16, 16, 400);
      check("t2_clear_writes", n_clr, 256);
      check("t2_mine_writes", n_mine, 0);
      check("t2_bad", n_bad, 0);
      check("t2_done", bus.alg_done, 1);
      check("t2_total", bus.mine_total, 0);

      // 3: 9x9 board, centre corner
      pulse_start(1, 10, 8'h00);
      watch(1, 0, 0, 9, 9, 3000);
      check("t3_clear_writes", n_clr, 256);
      check("t3_mine_writes", n_mine, 10);
      check("t3_dup", n_dup, 0);
      check("t3_bad_cell", n_bad, 0);
      check("t3_done", bus9.alg_done, 1);
      check("t3_total", bus9.mine_total, 10);

      // 4: too many mines -> ERR with no writes, then a legal request
      pulse_start(0, 41, 8'h77);
      check("t4_err", bus.alg_err, 1);
      check("t4_busy", bus.busy, 0);
      check("t4_done_cleared", bus.alg_done, 0);
      begin
         int wr_cnt;
         wr_cnt = 0;
         for (int i = 0; i < 8; i++) begin
            if (bus.mem_wren) wr_cnt++;
            @(negedge clk);
         end
         check("t4_no_writes", wr_cnt, 0);
      end
      check("t4_err_holds", bus.alg_err, 1);
      pulse_start(0, 40, 8'h77);
      check("t4_err_cleared", bus.alg_err, 0);
      watch(0, 7, 7, 16, 16, 3000);
      check("t4_rerun_mines", n_mine, 40);
      check("t4_rerun_bad", n_bad, 0);
      check("t4_rerun_done", bus.alg_done, 1);

      // 6a: rerun from DONE restarts mine_total; start mid-PLACE ignored
      pulse_start(0, 40, 8'h33);
      check("t6_total_restart", bus.mine_total, 0);
      check("t6_busy", bus.busy, 1);
      wait_total(5, 2000);
      pulse_start(0, 3, 8'h00);
      check("t6_busy_after_ignored", bus.busy, 1);
      check("t6_total_kept", longint'(int'(bus.mine_total) >= 5), 1);
      watch(0, 3, 3, 16, 16, 3000);
      check("t6_no_reclear", n_clr, 0);
      check("t6_total_final", bus.mine_total, 40);
      check("t6_done", bus.alg_done, 1);

      // 6b: asynchronous reset mid-PLACE
      pulse_start(0, 40, 8'h77);
      wait_total(3, 2000);
      #2 rst = 1'b0;
      #1;
      check("t6_async_reset_outputs", {bus.busy, bus.alg_done, bus.alg_err, bus.mine_total,
                                        bus.mem_addr, bus.mem_in, bus.mem_wren}, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_idle_after_reset", {bus.busy, bus.mem_wren}, 0);

      // 5: stuck random source
      stuck = 1'b1;
      pulse_start(0, 40, 8'h88);
      watch(0, 8, 8, 16, 16, 400);
      check("t5_one_mine", n_mine, 1);
      check("t5_mine_addr", first_mine, 0);
      check("t5_total", bus.mine_total, 1);
`ifdef MINE_FIELD_GEN_WATCHDOG_EN
      check("t5_err", bus.alg_err, 1);
      check("t5_busy", bus.busy, 0);
`else
      check("t5_still_busy", bus.busy, 1);
      check("t5_no_err", bus.alg_err, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
